pipe_hazard_tracker: RTL and testbench

//  Parametrised hazard/forwarding controller for the in-order ARM-subset pipeline; replaces the

---
 rtl/pipe_hazard_tracker.sv | 120 ++++++++++++
 tb/tb_pipe_hazard_tracker.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_tracker.sv
// rtl/pipe_hazard_tracker.sv - in-flight destination tracker: load-use stall, flush, registered forward selects.
// Optional HAZARD_STATS_EN adds saturating stall/flush event counters.
module pipe_hazard_tracker #(
  parameter int NUM_REGS    = 32,
  parameter int ZERO_REG    = 31,
  parameter int MEM_LAT     = 1,
  parameter int FLUSH_DEPTH = 1,
  localparam int RAW = $clog2(NUM_REGS),
  localparam int D   = MEM_LAT + 2,
  localparam int SW  = $clog2(D),
  localparam int CW  = $clog2(D + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           issue_valid,
  input  logic [RAW-1:0] issue_rs1,
  input  logic           issue_rs1_used,
  input  logic [RAW-1:0] issue_rs2,
  input  logic           issue_rs2_used,
  input  logic [RAW-1:0] issue_rd,
  input  logic           issue_rd_we,
  input  logic           issue_load,
  input  logic           flush,
  output logic           stall,
  output logic [SW-1:0]  fwd_a_sel,
  output logic [SW-1:0]  fwd_b_sel,
`ifdef HAZARD_STATS_EN
  output logic [15:0]    stat_stall_cycles,
  output logic [15:0]    stat_flushes,
`endif
  output logic [CW-1:0]  inflight
);

  localparam logic [RAW-1:0] ZR = RAW'(ZERO_REG);

  logic [D-1:0]          slot_valid, slot_we, slot_load;
  logic [D-1:0][RAW-1:0] slot_rd;
  logic [D-1:0]          nxt_valid, nxt_we, nxt_load;
  logic [D-1:0][RAW-1:0] nxt_rd;
  logic [CW-1:0]         nxt_count;

  logic          a_ld_early, b_ld_early;
  logic [SW-1:0] a_sel, b_sel;
  logic          accept;

  // Slot D-1 is retiring into the write-through register file, so it never
  // forwards; scanning downward leaves the youngest (lowest index) match.
  always_comb begin
    a_ld_early = 1'b0;
    b_ld_early = 1'b0;
    a_sel      = '0;
    b_sel      = '0;
    for (int k = D - 2; k >= 0; k--) begin
      if (slot_valid[k] && slot_we[k] && issue_rs1_used && issue_rs1 != ZR &&
          slot_rd[k] == issue_rs1) begin
        a_sel      = SW'(k + 1);
        a_ld_early = slot_load[k] && (k < D - 2);
      end
      if (slot_valid[k] && slot_we[k] && issue_rs2_used && issue_rs2 != ZR &&
          slot_rd[k] == issue_rs2) begin
        b_sel      = SW'(k + 1);
        b_ld_early = slot_load[k] && (k < D - 2);
      end
    end
  end

  assign stall  = issue_valid && !flush && (a_ld_early || b_ld_early);
  assign accept = issue_valid && !stall && !flush;

  always_comb begin
    nxt_valid    = '0;
    nxt_we       = slot_we;
    nxt_load     = slot_load;
    nxt_rd       = slot_rd;
    nxt_valid[0] = accept;
    nxt_we[0]    = issue_rd_we;
    nxt_load[0]  = issue_load;
    nxt_rd[0]    = issue_rd;
    for (int k = 1; k < D; k++) begin
      nxt_valid[k] = slot_valid[k-1] && !(flush && ((k - 1) < FLUSH_DEPTH));
      nxt_we[k]    = slot_we[k-1];
      nxt_load[k]  = slot_load[k-1];
      nxt_rd[k]    = slot_rd[k-1];
    end
    nxt_count = '0;
    for (int k = 0; k < D; k++) begin
      nxt_count = nxt_count + CW'(nxt_valid[k] && nxt_we[k]);
    end
  end

  always_ff @(posedge clk) begin
    slot_we   <= nxt_we;
    slot_load <= nxt_load;
    slot_rd   <= nxt_rd;
    if (reset) begin
      slot_valid <= '0;
      fwd_a_sel  <= '0;
      fwd_b_sel  <= '0;
      inflight   <= '0;
    end else begin
      slot_valid <= nxt_valid;
      fwd_a_sel  <= accept ? a_sel : '0;
      fwd_b_sel  <= accept ? b_sel : '0;
      inflight   <= nxt_count;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_stall_cycles <= '0;
      stat_flushes      <= '0;
    end else begin
      if (stall && stat_stall_cycles != 16'hFFFF) stat_stall_cycles <= stat_stall_cycles + 16'd1;
      if (flush && stat_flushes != 16'hFFFF)      stat_flushes      <= stat_flushes + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_tracker.sv
// tb/tb_pipe_hazard_tracker.sv - directed and random checks of two tracker builds against a timestamp model.
// Instance u0 uses defaults (D=3, flush depth 1); u1 uses MEM_LAT=2 (D=4) with flush depth 2.
module tb_pipe_hazard_tracker;

  logic       clk = 1'b0;
  logic       reset, issue_valid, issue_rs1_used, issue_rs2_used, issue_rd_we, issue_load, flush;
  logic [4:0] issue_rs1, issue_rs2, issue_rd;
  logic       stall0, stall1;
  logic [1:0] fa0, fb0, fa1, fb1;
  logic [1:0] inf0;
  logic [2:0] inf1;
`ifdef HAZARD_STATS_EN
  logic [15:0] ss0, sf0, ss1, sf1;
`endif

  always #5 clk = ~clk;

  pipe_hazard_tracker u0 (
    .clk(clk), .reset(reset), .issue_valid(issue_valid),
    .issue_rs1(issue_rs1), .issue_rs1_used(issue_rs1_used),
    .issue_rs2(issue_rs2), .issue_rs2_used(issue_rs2_used),
    .issue_rd(issue_rd), .issue_rd_we(issue_rd_we), .issue_load(issue_load),
    .flush(flush), .stall(stall0), .fwd_a_sel(fa0), .fwd_b_sel(fb0),
`ifdef HAZARD_STATS_EN
    .stat_stall_cycles(ss0), .stat_flushes(sf0),
`endif
    .inflight(inf0));

  pipe_hazard_tracker #(.MEM_LAT(2), .FLUSH_DEPTH(2)) u1 (
    .clk(clk), .reset(reset), .issue_valid(issue_valid),
    .issue_rs1(issue_rs1), .issue_rs1_used(issue_rs1_used),
    .issue_rs2(issue_rs2), .issue_rs2_used(issue_rs2_used),
    .issue_rd(issue_rd), .issue_rd_we(issue_rd_we), .issue_load(issue_load),
    .flush(flush), .stall(stall1), .fwd_a_sel(fa1), .fwd_b_sel(fb1),
`ifdef HAZARD_STATS_EN
    .stat_stall_cycles(ss1), .stat_flushes(sf1),
`endif
    .inflight(inf1));

  typedef struct {
    int   t;
    logic [4:0] rd;
    bit   we, ld, killed, used;
  } rec_t;

  rec_t recs [2][16];
  int   wp [2];
  int   exp_sa [2], exp_sb [2], exp_inf [2];
  bit   last_st [2];
  int   cyc = 0;
  bit   known = 0;
  int   n_vec = 0, n_err = 0;
  int   exp_ss = 0, exp_sf = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // An instruction accepted in cycle t sits in slot (n - t - 1) during cycle n.
  function automatic int youngest(input int inst, input int dd, input logic [4:0] rs, input bit used);
    int best = -1;
    int best_age = 1000;
    if (!used || rs == 5'd31) return -1;
    for (int j = 0; j < 16; j++) begin
      int age = cyc - recs[inst][j].t - 1;
      if (recs[inst][j].used && !recs[inst][j].killed && recs[inst][j].we &&
          recs[inst][j].rd == rs && age >= 0 && age <= dd - 2 && age < best_age) begin
        best = j;
        best_age = age;
      end
    end
    return best;
  endfunction

  task automatic model(input int inst, input int dd, input int fd, output bit st);
    int ya, yb, cnt, age;
    bit acc;
    ya = youngest(inst, dd, issue_rs1, issue_rs1_used);
    yb = youngest(inst, dd, issue_rs2, issue_rs2_used);
    st = 0;
    if (issue_valid && !flush) begin
      if (ya >= 0 && recs[inst][ya].ld && (cyc - recs[inst][ya].t - 1) < dd - 2) st = 1;
      if (yb >= 0 && recs[inst][yb].ld && (cyc - recs[inst][yb].t - 1) < dd - 2) st = 1;
    end
    acc = issue_valid && !st && !flush;
    exp_sa[inst] = (acc && ya >= 0) ? cyc - recs[inst][ya].t : 0;
    exp_sb[inst] = (acc && yb >= 0) ? cyc - recs[inst][yb].t : 0;
    if (flush) begin
      for (int j = 0; j < 16; j++) begin
        age = cyc - recs[inst][j].t - 1;
        if (recs[inst][j].used && age >= 0 && age < fd) recs[inst][j].killed = 1;
      end
    end
    if (acc) begin
      recs[inst][wp[inst]].t      = cyc;
      recs[inst][wp[inst]].rd     = issue_rd;
      recs[inst][wp[inst]].we     = issue_rd_we;
      recs[inst][wp[inst]].ld     = issue_load;
      recs[inst][wp[inst]].killed = 0;
      recs[inst][wp[inst]].used   = 1;
      wp[inst] = (wp[inst] + 1) % 16;
    end
    cnt = 0;
    for (int j = 0; j < 16; j++) begin
      age = cyc - recs[inst][j].t;
      if (recs[inst][j].used && !recs[inst][j].killed && recs[inst][j].we && age >= 0 && age <= dd - 1)
        cnt++;
    end
    exp_inf[inst] = cnt;
    if (reset) begin
      for (int j = 0; j < 16; j++) recs[inst][j].used = 0;
      exp_sa[inst] = 0;
      exp_sb[inst] = 0;
      exp_inf[inst] = 0;
    end
  endtask

  // Entered and left at posedge+1; registered outputs reflect the previous step.
  task automatic step(input bit rst, input bit v, input int r1, input bit u1, input int r2, input bit u2,
                      input int d, input bit w, input bit l, input bit f);
    bit st0, st1;
    if (known) begin
      check("fwd_a_u0", fa0, exp_sa[0]);
      check("fwd_b_u0", fb0, exp_sb[0]);
      check("inflight_u0", inf0, exp_inf[0]);
      check("fwd_a_u1", fa1, exp_sa[1]);
      check("fwd_b_u1", fb1, exp_sb[1]);
      check("inflight_u1", inf1, exp_inf[1]);
`ifdef HAZARD_STATS_EN
      check("stat_stall_u0", ss0, exp_ss);
      check("stat_flush_u0", sf0, exp_sf);
`endif
    end
    reset = rst;
    issue_valid = v;
    issue_rs1 = r1[4:0];
    issue_rs1_used = u1;
    issue_rs2 = r2[4:0];
    issue_rs2_used = u2;
    issue_rd = d[4:0];
    issue_rd_we = w;
    issue_load = l;
    flush = f;
    #1;
    model(0, 3, 1, st0);
    model(1, 4, 2, st1);
    if (known) begin
      check("stall_u0", stall0, st0);
      check("stall_u1", stall1, st1);
    end
    last_st[0] = stall0;
    last_st[1] = stall1;
    if (rst) begin
      exp_ss = 0;
      exp_sf = 0;
    end else begin
      if (st0 && exp_ss < 65535) exp_ss++;
      if (f && exp_sf < 65535) exp_sf++;
    end
    if (rst) known = 1;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alu(input int d, input int r1, input bit u1, input int r2, input bit u2);
    step(0, 1, r1, u1, r2, u2, d, 1, 0, 0);
  endtask

  task automatic ldur(input int d);
    step(0, 1, 0, 0, 0, 0, d, 1, 1, 0);
  endtask

  task automatic nop();
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s0, s1, r;
    wp[0] = 0;
    wp[1] = 0;
    @(posedge clk);
    #1;
    do_reset();
    do_reset();

    alu(1, 0, 0, 0, 0);
    alu(8, 1, 1, 0, 0);
    check("x1_no_stall", last_st[0], 0);
    check("x1_fwd_a", fa0, 1);

    do_reset();
    alu(2, 0, 0, 0, 0);
    nop();
    alu(9, 0, 0, 2, 1);
    check("x2_one_nop_fwd_b", fb0, 2);
    do_reset();
    alu(2, 0, 0, 0, 0);
    nop();
    nop();
    alu(9, 0, 0, 2, 1);
    check("x2_two_nop_fwd_b", fb0, 0);

    do_reset();
    ldur(3);
    s0 = 0;
    s1 = 0;
    alu(7, 3, 1, 0, 0);
    s0 += last_st[0];
    s1 += last_st[1];
    alu(7, 3, 1, 0, 0);
    s0 += last_st[0];
    s1 += last_st[1];
    check("ld_x3_fwd_a_u0", fa0, 2);
    alu(7, 3, 1, 0, 0);
    s0 += last_st[0];
    s1 += last_st[1];
    check("ld_x4_fwd_a_u1", fa1, 3);
    check("ld_stall_cycles_u0", s0, 1);
    check("ld_stall_cycles_u1", s1, 2);

    do_reset();
    ldur(31);
    alu(31, 31, 1, 31, 1);
    check("x31_no_stall", last_st[0], 0);
    alu(10, 31, 1, 31, 1);
    check("x31_fwd_a", fa0, 0);

    do_reset();
    alu(5, 0, 0, 0, 0);
    alu(5, 0, 0, 0, 0);
    alu(11, 5, 1, 0, 0);
    check("x5_youngest_fwd", fa0, 1);

    do_reset();
    ldur(6);
    step(0, 1, 6, 1, 0, 0, 12, 1, 0, 1);
    check("flush_no_stall", last_st[0], 0);
    check("flush_inflight_u0", inf0, 0);
    check("flush_inflight_u1", inf1, 0);

    ldur(6);
    step(1, 1, 6, 1, 0, 0, 12, 1, 0, 1);
    step(0, 1, 6, 1, 6, 1, 12, 1, 0, 0);
    check("reset_flush_stall", last_st[0], 0);

`ifdef HAZARD_STATS_EN
    do_reset();
    for (int p = 0; p < 3; p++) begin
      ldur(3);
      alu(7, 3, 1, 0, 0);
      alu(7, 3, 1, 0, 0);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    check("stats_stall", ss0, 3);
    check("stats_flush", sf0, 2);
`endif

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int ra, rb, rd;
      r = $urandom_range(0, 6); ra = (r == 6) ? 31 : r;
      r = $urandom_range(0, 6); rb = (r == 6) ? 31 : r;
      r = $urandom_range(0, 6); rd = (r == 6) ? 31 : r;
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
           ra, $urandom_range(0, 1), rb, $urandom_range(0, 1),
           rd, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 7) == 0);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
